// File: rtl/drip_valve_controller.sv
// drip_valve_controller: debounced, time-bounded drip valve driver with cooldown,
// abort on low level/disable, timeout fault and saturating drip-event counter.
module drip_valve_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_ON_CYCLES   = 8,
  parameter int MAX_ON_CYCLES   = 32,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int EVENT_W         = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               drip_state_i,
  input  logic               low_level_indicator_i,
  input  logic               fault_clr_i,
  output logic               valve_open_o,
  output logic               cooldown_o,
  output logic               fault_timeout_o,
  output logic [EVENT_W-1:0] drip_count_o
);
  typedef enum logic [1:0] {IDLE, OPEN, COOLDOWN} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_MIN  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_MAX  = CNT_W'(MAX_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  state_t             state_q, state_d;
  logic               req_db_q, req_db_d;
  logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EVENT_W-1:0] count_q, count_d;
  logic               fault_q, fault_d;
  logic               valve_q, cool_q;
  logic               abort, timeout, done, leave;
  always_comb begin
    db_cnt_d = (drip_state_i == req_db_q || db_cnt_q == DB_LAST) ? '0 : db_cnt_q + 1'b1;
    req_db_d = (drip_state_i != req_db_q && db_cnt_q == DB_LAST) ? drip_state_i : req_db_q;
  end
  // One counter serves both the open-time and the cooldown phases.
  always_comb begin
    abort   = low_level_indicator_i || !enable_i;
    timeout = cnt_q == ON_MAX;
    done    = !req_db_q && cnt_q >= ON_MIN;
    leave   = state_q == OPEN && (abort || timeout || done);
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (req_db_q && enable_i && !low_level_indicator_i) state_d = OPEN;
    end else if (state_q == OPEN) begin
      if (leave) begin
        state_d = COOLDOWN;
        cnt_d   = '0;
      end
    end else if (cnt_q == CD_LAST) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    fault_d = (leave && !abort && timeout) || (fault_q && !fault_clr_i);
    count_d = (leave && count_q != '1) ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_db_q <= 1'b0;
      db_cnt_q <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
      valve_q  <= 1'b0;
      cool_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_db_q <= req_db_d;
      db_cnt_q <= db_cnt_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      valve_q  <= state_d == OPEN;
      cool_q   <= state_d == COOLDOWN;
    end
  end
  assign valve_open_o    = valve_q;
  assign cooldown_o      = cool_q;
  assign fault_timeout_o = fault_q;
  assign drip_count_o    = count_q;
endmodule

// File: tb/tb_drip_valve_controller.sv
// tb_drip_valve_controller: scoreboard bench comparing the valve controller against a cycle-count model
module tb_drip_valve_controller;
  localparam int DEB = 4, MIN = 8, MAX = 32, COOL = 16;
  typedef struct packed {
    logic       v;
    logic       c;
    logic       f;
    logic [7:0] n;
  } exp_t;
  logic clk = 0, rst = 1, ena = 1, drip = 0, lowl = 0, clr = 0;
  logic       valve, cool, fault;
  logic [7:0] count;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  bit m_req, m_prev, m_fault;
  int m_run, m_age, m_cd, m_cnt;
  drip_valve_controller dut (
    .clk_i(clk), .rst_i(rst), .enable_i(ena), .drip_state_i(drip),
    .low_level_indicator_i(lowl), .fault_clr_i(clr),
    .valve_open_o(valve), .cooldown_o(cool), .fault_timeout_o(fault), .drip_count_o(count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if ({valve, cool, fault, count} !== e) begin
        miscompares++;
        $display("FAIL vec %0d t=%0t valve/cool/fault/count got %b %b %b %0d expected %b %b %b %0d",
                 vectors, $time, valve, cool, fault, count, e.v, e.c, e.f, e.n);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $finish;
  end
  task automatic model_reset();
    m_req = 0; m_prev = 0; m_fault = 0;
    m_run = 0; m_age = 0; m_cd = 0; m_cnt = 0;
  endtask
  task automatic model(input bit d, input bit en, input bit low, input bit cl);
    bit tmo, ab;
    tmo = 0;
    ab = low || !en;
    m_run = (d == m_prev) ? m_run + 1 : 1;
    m_prev = d;
    if (m_cd > 0) m_cd--;
    else if (m_age > 0) begin
      if (ab || m_age == MAX || (!m_req && m_age >= MIN)) begin
        tmo = !ab && m_age == MAX;
        m_age = 0;
        m_cd = COOL;
        if (m_cnt < 255) m_cnt++;
      end else m_age++;
    end else if (m_req && en && !low) m_age = 1;
    m_fault = tmo ? 1'b1 : (cl ? 1'b0 : m_fault);
    if (d != m_req && m_run >= DEB) m_req = d;
  endtask
  task automatic cyc(input bit d, input bit en = 1, input bit low = 0, input bit cl = 0);
    drip = d; ena = en; lowl = low; clr = cl;
    @(posedge clk);
    #1;
    model(d, en, low, cl);
    q.push_back('{v: m_age > 0, c: m_cd > 0, f: m_fault, n: 8'(m_cnt)});
  endtask
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1; drip = 0; ena = 1; lowl = 0; clr = 0;
    #1;
    vectors++;
    if ({valve, cool, fault, count} !== '0) begin
      miscompares++;
      $display("FAIL reset t=%0t valve/cool/fault/count got %b %b %b %0d expected all 0",
               $time, valve, cool, fault, count);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    model_reset();
    async_reset();
    repeat (3) cyc(0);
    repeat (3) cyc(1);
    repeat (30) cyc(0);
    repeat (20) cyc(1);
    repeat (30) cyc(0);
    repeat (5) cyc(1);
    repeat (30) cyc(0);
    repeat (10) cyc(1);
    cyc(1, 1, 1);
    repeat (30) cyc(0);
    repeat (8) cyc(1);
    async_reset();
    repeat (10) cyc(0);
    repeat (90) cyc(1);
    repeat (40) cyc(0);
    cyc(0, 1, 0, 1);
    repeat (3) cyc(0);
    repeat (10) cyc(1);
    cyc(1, 0, 0);
    repeat (30) cyc(0);
    repeat (20) cyc(1, 1, 1);
    repeat (30) cyc(0);
    repeat (20) cyc(1, 0, 0);
    repeat (30) cyc(0);
    repeat (60) begin
      bit d;
      int len;
      d = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 45);
      repeat (len) cyc(d, $urandom_range(0, 39) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
    end
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %0d expected vectors never compared", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/drip_valve_controller.md
# drip_valve_controller

Sequential drive stage downstream of the combinational drip trigger. It turns the raw drip request into a safe, timed valve command:
- debounces the request;
- enforces minimum and maximum open times and a post-close cooldown;
- aborts on low tank level or disable;
- counts completed drip cycles and flags timeouts.

Its outputs drive the drip valve actuator and status display.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive identical samples needed to change the debounced request (≥1)
- MIN_ON_CYCLES, 8, minimum valve-open cycles once opened, unless aborted (≥1)
- MAX_ON_CYCLES, 32, maximum valve-open cycles; reaching it raises timeout fault (≥MIN_ON_CYCLES)
- COOLDOWN_CYCLES, 16, forced closed cycles after every close (≥1)
- CNT_W, 8, width of internal cycle counters; all cycle parameters ≤ 2^CNT_W
- EVENT_W, 8, width of drip_count_o
- clk_i  in  1  system clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  master enable; low blocks opening and aborts an open valve
- drip_state_i  in  1  raw drip request from drip trigger
- low_level_indicator_i  in  1  tank below safe level; blocks opening and aborts an open valve
- fault_clr_i  in  1  synchronous clear of fault_timeout_o
- valve_open_o  out  1  valve command, registered
- cooldown_o  out  1  high while in COOLDOWN, registered
- fault_timeout_o  out  1  sticky: valve closed by MAX_ON_CYCLES limit
- drip_count_o  out  EVENT_W  completed open periods, saturating

## Operation
- Reset (async, any time, including mid-open): state=IDLE, all counters 0, debounced request 0, all outputs 0.
- Debounce: req_db register and db_cnt.
  - If the sample equals req_db, db_cnt clears.
  - Otherwise db_cnt increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, req_db takes the input and db_cnt clears.
- States: IDLE, OPEN, COOLDOWN. valve_open_o = (state==OPEN); cooldown_o = (state==COOLDOWN).
- IDLE:
  - Goes to OPEN when req_db & enable_i & !low_level_indicator_i.
  - on_cnt clears on entry to OPEN.
- OPEN:
  - on_cnt increments on every edge that remains in OPEN.
  - on_cnt+1 = cycles open so far.
  - Exit to COOLDOWN, in priority order:
    1. Abort: low_level_indicator_i | !enable_i. Closes immediately, ignoring MIN_ON.
    2. Timeout: on_cnt == MAX_ON_CYCLES-1. Also sets fault_timeout_o.
    3. Normal: !req_db & on_cnt ≥ MIN_ON_CYCLES-1.
- Every exit from OPEN increments drip_count_o by 1. The count holds at 2^EVENT_W-1.
- COOLDOWN:
  - cd_cnt clears on entry and increments each edge.
  - Goes to IDLE when cd_cnt == COOLDOWN_CYCLES-1, giving exactly COOLDOWN_CYCLES cycles.
  - enable_i and level inputs are ignored.
- A request still held at the end of cooldown reopens the valve on the next edge from IDLE.
- fault_timeout_o is set by a timeout exit and cleared by fault_clr_i. If both occur on the same edge, set wins.

## Timing
- Let edge 0 be the first edge sampling drip_state_i=1.
  - req_db rises after edge DEBOUNCE_CYCLES-1.
  - valve_open_o rises after edge DEBOUNCE_CYCLES (defaults: edge 4).
- A falling request has the same DEBOUNCE_CYCLES+1 edge latency to valve close, subject to MIN_ON.
- Valve-open duration = clamp(debounced request length, MIN_ON_CYCLES, MAX_ON_CYCLES), unless aborted.
- An abort seen at edge n makes valve_open_o low after edge n (1-cycle latency).
- drip_count_o and fault_timeout_o update on the same edge valve_open_o falls.
- No combinational input-to-output paths.

## Test plan
- Reset:
  - Assert rst_i mid-OPEN with count=3: all outputs 0 immediately, without a clock.
  - After release with request low: outputs stay 0.
- Glitch rejection: drip_state_i high for edges 0–2 only, enable=1 -> valve_open_o never asserts; drip_count_o=0.
- Normal cycle: drip_state_i high for edges 0–19, then low ->
  - valve high after edge 4 through edge 24 (20 cycles);
  - drip_count_o=1 at edge 24;
  - cooldown_o high edges 24–40;
  - IDLE after edge 40; fault_timeout_o=0.
- Minimum on: drip_state_i high for edges 0–4 only -> valve high for 8 cycles, after edge 4 to edge 12, then 16 cooldown cycles.
- Timeout/repeat: drip_state_i held high ->
  - valve high edges 4–36; fault_timeout_o=1 at edge 36;
  - cooldown to edge 52; valve reopens after edge 53 for 32 cycles; drip_count_o=2 at edge 85;
  - fault_clr_i pulse clears fault_timeout_o.
- Abort/block:
  - low_level_indicator_i=1 at edge 10 while open -> valve low after edge 10, drip_count_o=1, cooldown 16 cycles.
  - Held low-level in IDLE with request high -> valve stays 0.
  - Same checks with enable_i=0.
